seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PW, default 8: maximum pattern width in bits.
REQ-002 SHALL have parameter RW, default 4: repeat-count width.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 SHALL have port pattern  input  PW  bits to send, MSB-first from bit plen down to bit 0.
REQ-007 SHALL have port plen  input  $clog2(PW)  active length minus 1, so 0 means 1 bit and PW-1 means PW bits.
REQ-008 SHALL have port reps  input  RW  extra repetitions; total sends = reps+1.
REQ-009 SHALL have port gap_en  input  1  insert one idle cycle between repetitions.
REQ-010 SHALL have port dout_ready  input  1  downstream accepts the current bit.
REQ-011 SHALL have port dout  output  1  serial data bit.
REQ-012 SHALL have port dout_valid  output  1  dout holds a bit to be consumed.
REQ-013 SHALL have port busy  output  1  high in SHIFT and GAP.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the last bit of the last repetition is accepted.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, SHIFT, GAP and DONE; every output SHALL be registered or decoded from state only, never from inputs combinationally.
REQ-016 IDLE with start=1 SHALL capture pattern, plen, reps and gap_en into internal registers, load bit index = plen and rep count = reps, and move to SHIFT.
REQ-017 SHIFT SHALL drive dout = captured pattern[index] with dout_valid=1.
REQ-018 A bit transfer occurs when dout_valid and dout_ready are both 1 on a rising edge.
REQ-019 With dout_ready=0, dout, index and state SHALL hold unchanged indefinitely.
REQ-020 On a transfer with index>0, index SHALL decrement by 1.
REQ-021 On a transfer with index=0 and rep count>0, rep count SHALL decrement and index SHALL reload from captured plen; next state SHALL be GAP if gap_en, else SHIFT.
REQ-022 On a transfer with index=0 and rep count=0, the next state SHALL be DONE.
REQ-023 GAP SHALL last exactly one cycle with dout=0 and dout_valid=0, independent of dout_ready, then return to SHIFT.
REQ-024 DONE SHALL assert done=1 for exactly one cycle with busy=0 and dout_valid=0, then go to IDLE.
REQ-025 start asserted in SHIFT, GAP or DONE SHALL be ignored.
REQ-026 Changes to pattern, plen, reps or gap_en after capture SHALL not affect a transmission in progress.
REQ-027 Latency SHALL be: start sampled on edge N gives the first bit valid in cycle N+1; total valid cycles = (plen+1)*(reps+1) when dout_ready is held high.
REQ-028 start=1 held continuously SHALL launch a new transmission on the IDLE cycle after DONE, giving back-to-back frames separated by one DONE cycle and one IDLE cycle.
REQ-029 The FSM SHALL return to IDLE from any unused state encoding.

Reset
REQ-030 RST=1 SHALL immediately force state IDLE and dout=0, dout_valid=0, busy=0, done=0, and clear index, rep count and all captured registers, including mid-transmission.
REQ-031 After RST deasserts, no transmission SHALL begin until start is sampled high in IDLE.

Structure
REQ-032 The state encodings (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11) and the PW/RW defaults SHALL live in the shared sequence package used by the sequence detectors.
REQ-033 The block SHALL be a single module with the shift index, repeat counter and FSM inline; no sub-module.

Verification
REQ-034 pattern=8'b00000101, plen=2, reps=1, gap_en=0, ready=1 -> dout 1,0,1,1,0,1 on six consecutive valid cycles, then a done pulse; feeding this into the team's 101 sequence detector SHALL give detections.
REQ-035 Same stimulus with gap_en=1 -> 1,0,1, one cycle with dout_valid=0, then 1,0,1, then done.
REQ-036 pattern=8'hA5, plen=7, reps=0, with dout_ready low for 3 cycles after the second bit -> second bit (0) held for 3 cycles, full sequence 1,0,1,0,0,1,0,1, one done pulse.
REQ-037 RST pulsed during the fourth bit of an 8-bit send -> outputs zero immediately, state IDLE, no done pulse; the next start sends the full new pattern.
REQ-038 start pulsed during SHIFT, and pattern changed mid-frame -> transmission unaffected, only one done pulse.
REQ-039 plen=0, reps=15, pattern bit0=1 -> sixteen valid cycles of dout=1, then done.

Source files
------------

// File: rtl/seq_pattern_tx_pkg.sv
// Shared sequence package: FSM encodings and default widths used by the
// sequence detectors and the pattern transmitter.
package seq_pattern_tx_pkg;

   localparam int SEQ_PW_DEF = 8;
   localparam int SEQ_RW_DEF = 4;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_GAP   = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends pattern[plen:0] MSB-first, reps+1 times,
// over a valid/ready bit stream with an optional idle gap between repeats.
module seq_pattern_tx
   import seq_pattern_tx_pkg::*;
#(
   parameter int PW = SEQ_PW_DEF,
   parameter int RW = SEQ_RW_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [PW-1:0]         pattern,
   input  logic [$clog2(PW)-1:0] plen,
   input  logic [RW-1:0]         reps,
   input  logic                  gap_en,
   input  logic                  dout_ready,
   output logic                  dout,
   output logic                  dout_valid,
   output logic                  busy,
   output logic                  done
);

   localparam int IW = $clog2(PW);

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] pat_q,   pat_d;
   logic [IW-1:0] plen_q,  plen_d;
   logic          gap_q,   gap_d;
   logic [IW-1:0] idx_q,   idx_d;
   logic [RW-1:0] rep_q,   rep_d;

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      plen_d  = plen_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pat_d   = pattern;
               plen_d  = plen;
               gap_d   = gap_en;
               idx_d   = plen;
               rep_d   = reps;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (dout_ready) begin
               if (idx_q != '0) begin
                  idx_d = idx_q - 1'b1;
               end else if (rep_q != '0) begin
                  rep_d   = rep_q - 1'b1;
                  idx_d   = plen_q;
                  state_d = gap_q ? ST_GAP : ST_SHIFT;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_GAP:  state_d = ST_SHIFT;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         pat_q   <= '0;
         plen_q  <= '0;
         gap_q   <= 1'b0;
         idx_q   <= '0;
         rep_q   <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         plen_q  <= plen_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
      end
   end

   // Outputs decode from state and captured registers only
   assign dout_valid = (state_q == ST_SHIFT);
   assign dout       = dout_valid & pat_q[idx_q];
   assign busy       = (state_q == ST_SHIFT) || (state_q == ST_GAP);
   assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: frame-level expected-bit model checked every
// cycle, plus literal expectations for directed frames.
module tb_seq_pattern_tx;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       start = 1'b0;
   logic [7:0] pattern = '0;
   logic [2:0] plen = '0;
   logic [3:0] reps = '0;
   logic       gap_en = 1'b0;
   logic       dout_ready = 1'b1;
   logic       dout, dout_valid, busy, done;

   int n_chk = 0;
   int n_pass = 0;

   localparam int T_NEXT = 0;
   localparam int T_GAP  = 1;
   localparam int T_END  = 2;

   localparam int M_IDLE = 0;
   localparam int M_BITS = 1;
   localparam int M_GAP  = 2;
   localparam int M_END  = 3;

   bit exp_bits[$];
   int exp_tags[$];
   bit acc_log[$];
   int mode = M_IDLE;
   int tag_now;
   int valid_cnt = 0;
   int busy_cnt = 0;
   int done_cnt = 0;

   always #5 CLK = ~CLK;

   seq_pattern_tx dut (
      .CLK(CLK), .RST(RST), .start(start), .pattern(pattern),
      .plen(plen), .reps(reps), .gap_en(gap_en),
      .dout_ready(dout_ready), .dout(dout), .dout_valid(dout_valid),
      .busy(busy), .done(done)
   );

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
   endtask

   // Expected frame: every accepted bit, tagged with what must follow it
   function automatic void load_frame(input logic [7:0] p, input int pl,
                                      input int rp, input bit g);
      exp_bits.delete();
      exp_tags.delete();
      for (int r = 0; r <= rp; r++)
         for (int i = pl; i >= 0; i--) begin
            exp_bits.push_back(p[i]);
            if (i != 0) exp_tags.push_back(T_NEXT);
            else if (r == rp) exp_tags.push_back(T_END);
            else exp_tags.push_back(g ? T_GAP : T_NEXT);
         end
   endfunction

   initial forever begin
      @(negedge CLK);
      if (RST) begin
         chk("rst_dout", dout, 0);
         chk("rst_valid", dout_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         exp_bits.delete();
         exp_tags.delete();
         mode = M_IDLE;
      end else begin
         if (dout_valid) valid_cnt++;
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         case (mode)
            M_IDLE: begin
               chk("idle_valid", dout_valid, 0);
               chk("idle_busy", busy, 0);
               chk("idle_done", done, 0);
               if (start) begin
                  load_frame(pattern, int'(plen), int'(reps), gap_en);
                  mode = M_BITS;
               end
            end
            M_BITS: begin
               chk("bit_valid", dout_valid, 1);
               chk("bit_busy", busy, 1);
               chk("bit_done", done, 0);
               if (exp_bits.size() == 0) begin
                  chk("model_underrun", 1, 0);
                  mode = M_IDLE;
               end else begin
                  chk("bit_dout", dout, exp_bits[0]);
                  if (dout_ready) begin
                     acc_log.push_back(dout);
                     void'(exp_bits.pop_front());
                     tag_now = exp_tags.pop_front();
                     if (tag_now == T_GAP) mode = M_GAP;
                     else if (tag_now == T_END) mode = M_END;
                  end
               end
            end
            M_GAP: begin
               chk("gap_valid", dout_valid, 0);
               chk("gap_dout", dout, 0);
               chk("gap_busy", busy, 1);
               chk("gap_done", done, 0);
               mode = M_BITS;
            end
            default: begin
               chk("end_done", done, 1);
               chk("end_valid", dout_valid, 0);
               chk("end_busy", busy, 0);
               mode = M_IDLE;
            end
         endcase
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic launch(input logic [7:0] p, input logic [2:0] pl,
                         input logic [3:0] rp, input logic g);
      pattern = p; plen = pl; reps = rp; gap_en = g;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int k;
      k = 0;
      while (done_cnt < target && k < budget) begin
         cyc(1);
         k++;
      end
      chk("done_timeout", int'(done_cnt >= target), 1);
   endtask

   function automatic int bits_from(input int from);
      int v;
      v = 0;
      for (int i = from; i < acc_log.size(); i++) v = (v << 1) | int'(acc_log[i]);
      return v;
   endfunction

   int b0, v0, s0, d0;

   task automatic snap();
      b0 = acc_log.size();
      v0 = valid_cnt;
      s0 = busy_cnt;
      d0 = done_cnt;
   endtask

   initial begin
      cyc(2);
      RST = 1'b0;
      cyc(3);
      chk("no_start_no_valid", valid_cnt, 0);

      // 101 repeated twice, no gap
      snap();
      launch(8'h05, 3'd2, 4'd1, 1'b0);
      chk("t1_first_latency", dout_valid, 1);
      wait_done(d0 + 1, 40);
      cyc(2);
      chk("t1_bits", bits_from(b0), 'b101101);
      chk("t1_nbits", acc_log.size() - b0, 6);
      chk("t1_valid", valid_cnt - v0, 6);
      chk("t1_busy", busy_cnt - s0, 6);
      chk("t1_dones", done_cnt - d0, 1);

      // same with gap
      snap();
      launch(8'h05, 3'd2, 4'd1, 1'b1);
      wait_done(d0 + 1, 40);
      cyc(2);
      chk("t2_bits", bits_from(b0), 'b101101);
      chk("t2_valid", valid_cnt - v0, 6);
      chk("t2_busy", busy_cnt - s0, 7);
      chk("t2_dones", done_cnt - d0, 1);

      // stall on the second bit
      snap();
      launch(8'hA5, 3'd7, 4'd0, 1'b0);
      cyc(1);
      dout_ready = 1'b0;
      cyc(3);
      dout_ready = 1'b1;
      wait_done(d0 + 1, 40);
      cyc(2);
      chk("t3_bits", bits_from(b0), 'hA5);
      chk("t3_nbits", acc_log.size() - b0, 8);
      chk("t3_valid", valid_cnt - v0, 11);
      chk("t3_dones", done_cnt - d0, 1);

      // reset during the fourth bit
      snap();
      launch(8'h3C, 3'd7, 4'd0, 1'b0);
      cyc(3);
      #1 RST = 1'b1;
      #1;
      chk("t4_rst_dout", dout, 0);
      chk("t4_rst_valid", dout_valid, 0);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_done", done, 0);
      chk("t4_partial", acc_log.size() - b0, 3);
      cyc(1);
      RST = 1'b0;
      cyc(4);
      chk("t4_no_done", done_cnt - d0, 0);
      chk("t4_valid", valid_cnt - v0, 3);
      snap();
      launch(8'h96, 3'd7, 4'd0, 1'b0);
      wait_done(d0 + 1, 40);
      cyc(2);
      chk("t4_new_bits", bits_from(b0), 'h96);
      chk("t4_new_nbits", acc_log.size() - b0, 8);

      // start and inputs changed mid-frame
      snap();
      launch(8'hC3, 3'd7, 4'd1, 1'b0);
      cyc(3);
      start = 1'b1; pattern = 8'hFF; plen = 3'd1; reps = 4'd0; gap_en = 1'b1;
      cyc(1);
      start = 1'b0;
      wait_done(d0 + 1, 60);
      cyc(6);
      chk("t5_bits", bits_from(b0), 'hC3C3);
      chk("t5_nbits", acc_log.size() - b0, 16);
      chk("t5_valid", valid_cnt - v0, 16);
      chk("t5_dones", done_cnt - d0, 1);

      // single-bit pattern, 16 sends
      snap();
      launch(8'h01, 3'd0, 4'd15, 1'b0);
      wait_done(d0 + 1, 60);
      cyc(2);
      chk("t6_bits", bits_from(b0), 'hFFFF);
      chk("t6_nbits", acc_log.size() - b0, 16);
      chk("t6_valid", valid_cnt - v0, 16);
      chk("t6_dones", done_cnt - d0, 1);

      // start held high: back-to-back frames
      snap();
      pattern = 8'h05; plen = 3'd2; reps = 4'd0; gap_en = 1'b0;
      start = 1'b1;
      wait_done(d0 + 2, 60);
      start = 1'b0;
      cyc(4);
      chk("t7_bits", bits_from(b0), 'b101101);
      chk("t7_valid", valid_cnt - v0, 6);
      chk("t7_dones", done_cnt - d0, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
